servo_motion_sequencer: RTL and testbench

SERVO_MOTION_SEQUENCER -- requirements
Module: servo_motion_sequencer

---
 rtl/servo_motion_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_servo_motion_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_motion_sequencer.sv
`timescale 1ns/1ps
// Two-servo motion sequencer: queues {speed1, speed2, hold frames} commands and plays them out
// on a frame clock. Define SERVO_RAMP_EN to rate-limit speed changes per frame.
module servo_motion_sequencer #(
  parameter int unsigned FRAME_CYCLES = 800000,
  parameter int unsigned RAMP_STEP    = 4,
  parameter logic [7:0]  NEUTRAL      = 8'd128
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_speed1,
  input  logic [7:0] cmd_speed2,
  input  logic [7:0] cmd_frames,
  input  logic       abort,
  output logic [7:0] speed1,
  output logic [7:0] speed2,
  output logic       busy,
  output logic       done
);

  localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;

  typedef struct packed {
    logic [7:0] spd1;
    logic [7:0] spd2;
    logic [7:0] frames;
  } cmd_t;

  // Move cur toward tgt by at most RAMP_STEP, clamped so it lands exactly on tgt.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [9:0] diff;
    logic signed [9:0] lim;
    lim  = $signed(10'(RAMP_STEP));
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    if (diff > lim)
      diff = lim;
    else if (diff < -lim)
      diff = -lim;
    return 8'($signed({2'b00, cur}) + diff);
  endfunction

  logic [FCW-1:0] frame_cnt;
  logic           frame_tick;

  assign frame_tick = (frame_cnt == FRAME_LAST);

  always_ff @(posedge Clock) begin
    if (Reset || frame_tick)
      frame_cnt <= '0;
    else
      frame_cnt <= frame_cnt + 1'b1;
  end

  // Command FIFO: four entries, count-based full/empty.
  cmd_t       fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  cmd_t       head;
  state_t     state;
  state_t     state_nxt;

  assign cmd_ready  = (count != 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign push       = cmd_valid && cmd_ready && !abort;
  assign pop        = (state == LOAD) && !fifo_empty && !abort;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (Reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push)
      fifo_mem[wr_ptr] <= {cmd_speed1, cmd_speed2, cmd_frames};
  end

  logic [7:0] target1;
  logic [7:0] target2;
  logic [7:0] hold_cnt;
  logic       aborted;
  logic       at_target;
  logic       hold_done;

  assign at_target = (speed1 == target1) && (speed2 == target2);
  assign hold_done = (hold_cnt == 8'd0);
  assign busy      = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // An aborted command returns to NEUTRAL and leaves HOLD silently.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = LOAD;
      LOAD: state_nxt = RAMP;
      RAMP: if (at_target) state_nxt = HOLD;
      HOLD: begin
        if (hold_done) begin
          done      = !aborted;
          state_nxt = (!aborted && !fifo_empty) ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = RAMP;
      done      = 1'b0;
    end
    if (Reset)
      done = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      speed1   <= NEUTRAL;
      speed2   <= NEUTRAL;
      target1  <= NEUTRAL;
      target2  <= NEUTRAL;
      hold_cnt <= 8'd0;
      aborted  <= 1'b0;
    end else if (abort) begin
      target1  <= NEUTRAL;
      target2  <= NEUTRAL;
      hold_cnt <= 8'd0;
      aborted  <= 1'b1;
`ifndef SERVO_RAMP_EN
      speed1   <= NEUTRAL;
      speed2   <= NEUTRAL;
`endif
    end else begin
      case (state)
        LOAD: begin
          target1  <= head.spd1;
          target2  <= head.spd2;
          hold_cnt <= head.frames;
          aborted  <= 1'b0;
`ifndef SERVO_RAMP_EN
          speed1   <= head.spd1;
          speed2   <= head.spd2;
`endif
        end
        RAMP: begin
`ifdef SERVO_RAMP_EN
          if (frame_tick) begin
            speed1 <= ramp_toward(speed1, target1);
            speed2 <= ramp_toward(speed2, target2);
          end
`endif
        end
        HOLD: begin
          if (hold_done)
            aborted <= 1'b0;
          else if (frame_tick)
            hold_cnt <= hold_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
`timescale 1ns/1ps
// Directed bench for servo_motion_sequencer (FRAME_CYCLES = 10); expectations follow SERVO_RAMP_EN.
module tb_servo_motion_sequencer;

  localparam int unsigned FC   = 10;
  localparam int unsigned STEP = 4;
  localparam logic [7:0]  NEU  = 8'd128;

  logic       Clock;
  logic       Reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_speed1;
  logic [7:0] cmd_speed2;
  logic [7:0] cmd_frames;
  logic       abort;
  logic [7:0] speed1;
  logic [7:0] speed2;
  logic       busy;
  logic       done;

  servo_motion_sequencer #(
    .FRAME_CYCLES(FC),
    .RAMP_STEP   (STEP),
    .NEUTRAL     (NEU)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_speed1(cmd_speed1),
    .cmd_speed2(cmd_speed2),
    .cmd_frames(cmd_frames),
    .abort     (abort),
    .speed1    (speed1),
    .speed2    (speed2),
    .busy      (busy),
    .done      (done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Edges since reset; frame ticks land on edges that are multiples of FC.
  int edge_n = 0;
  always @(posedge Clock) edge_n <= Reset ? 0 : edge_n + 1;

  int done_total = 0;
  always @(negedge Clock) if (done === 1'b1) done_total++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int exp_next(input int o, input int t);
`ifdef SERVO_RAMP_EN
    if (t > o) return (t - o > int'(STEP)) ? o + int'(STEP) : t;
    if (t < o) return (o - t > int'(STEP)) ? o - int'(STEP) : t;
    return o;
`else
    return t;
`endif
  endfunction

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] frames;
    int         ch1;
    int         ch2;
  } vec_t;

  vec_t vecs [7];

  task automatic push_cmd(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] f);
    cmd_speed1 = s1;
    cmd_speed2 = s2;
    cmd_frames = f;
    cmd_valid  = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    cmd_valid  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input int prev1, input int prev2);
    vec_t v = vecs[idx];
    int p1, p2, c1, c2, last_k, done_k, e1, e2, d;
    bit step_ok;
    bit tick_ok;
    c1 = 0; c2 = 0; last_k = -1; done_k = -1; step_ok = 1; tick_ok = 1;
`ifdef SERVO_RAMP_EN
    e1 = v.ch1;
    e2 = v.ch2;
`else
    e1 = (int'(v.s1) != prev1) ? 1 : 0;
    e2 = (int'(v.s2) != prev2) ? 1 : 0;
`endif
    @(negedge Clock);
    check($sformatf("vec%0d_ready", idx), cmd_ready, 1);
    push_cmd(v.s1, v.s2, v.frames);
    p1 = speed1;
    p2 = speed2;
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clock);
      if (int'(speed1) != p1) begin
        c1++;
        last_k = edge_n;
        if (int'(speed1) != exp_next(p1, v.s1)) step_ok = 0;
`ifdef SERVO_RAMP_EN
        if (edge_n % FC != 0) tick_ok = 0;
`endif
      end
      if (int'(speed2) != p2) begin
        c2++;
        last_k = edge_n;
        if (int'(speed2) != exp_next(p2, v.s2)) step_ok = 0;
`ifdef SERVO_RAMP_EN
        if (edge_n % FC != 0) tick_ok = 0;
`endif
      end
      p1 = speed1;
      p2 = speed2;
      if (done === 1'b1) begin
        done_k = edge_n;
        break;
      end
    end
    check($sformatf("vec%0d_done_seen", idx), done_k >= 0, 1);
    check($sformatf("vec%0d_speed1", idx), speed1, v.s1);
    check($sformatf("vec%0d_speed2", idx), speed2, v.s2);
    check($sformatf("vec%0d_changes1", idx), c1, e1);
    check($sformatf("vec%0d_changes2", idx), c2, e2);
    check($sformatf("vec%0d_step_ok", idx), step_ok, 1);
    check($sformatf("vec%0d_tick_ok", idx), tick_ok, 1);
    d = done_k - last_k;
`ifdef SERVO_RAMP_EN
    check($sformatf("vec%0d_hold_time", idx), d, (v.frames == 0) ? 1 : 10 * int'(v.frames));
`else
    if (v.frames == 0)
      check($sformatf("vec%0d_hold_time", idx), d, 1);
    else
      check_range($sformatf("vec%0d_hold_time", idx), d,
                  10 * (int'(v.frames) - 1) + 2, 10 * (int'(v.frames) - 1) + 11);
`endif
    @(negedge Clock);
    check($sformatf("vec%0d_done_pulse_end", idx), done, 0);
    check($sformatf("vec%0d_idle_after", idx), busy, 0);
  endtask

  logic [7:0] fs1 [6];
  logic [7:0] fs2 [6];
  logic [7:0] ffr [6];

  task automatic fifo_test();
    int held;
    int nd;
    fs1 = '{8'd132, 8'd136, 8'd136, 8'd128, 8'd128, 8'd124};
    fs2 = '{8'd128, 8'd128, 8'd132, 8'd132, 8'd128, 8'd128};
    ffr = '{8'd3,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    held = 0;
    nd = 0;
    @(negedge Clock);
    fork
      begin
        push_cmd(fs1[0], fs2[0], ffr[0]);
        repeat (2) @(negedge Clock);
        for (int i = 1; i < 6; i++) begin
          cmd_speed1 = fs1[i];
          cmd_speed2 = fs2[i];
          cmd_frames = ffr[i];
          cmd_valid  = 1'b1;
          if (i == 5) check("fifo_full_ready", cmd_ready, 0);
          while (!cmd_ready && held < 300) begin
            @(negedge Clock);
            held++;
          end
          @(posedge Clock);
          @(negedge Clock);
        end
        cmd_valid = 1'b0;
        check_range("fifo_fifth_held", held, 1, 299);
      end
      begin
        for (int c = 0; c < 2000 && nd < 6; c++) begin
          @(negedge Clock);
          if (done === 1'b1) begin
            check($sformatf("fifo_done%0d_speed1", nd), speed1, fs1[nd]);
            check($sformatf("fifo_done%0d_speed2", nd), speed2, fs2[nd]);
            nd++;
          end
        end
        check("fifo_done_count", nd, 6);
      end
    join
    @(negedge Clock);
    check("fifo_idle_after", busy, 0);
  endtask

  task automatic wait_speed1(input logic [7:0] val, input string name);
    int w;
    w = 0;
    while (speed1 !== val && w < 400) begin
      @(negedge Clock);
      w++;
    end
    check(name, speed1 === val, 1);
  endtask

  task automatic abort_test();
    int d0;
    int w;
    d0 = done_total;
    @(negedge Clock);
    push_cmd(8'd160, 8'd128, 8'd5);
    push_cmd(8'd140, 8'd128, 8'd0);
    push_cmd(8'd120, 8'd128, 8'd0);
    wait_speed1(8'd160, "abort_reach_160");
    repeat (15) @(negedge Clock);
    check("abort_busy_before", busy, 1);
    abort      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_speed1 = 8'd50;
    cmd_speed2 = 8'd50;
    cmd_frames = 8'd0;
    @(negedge Clock);
    abort     = 1'b0;
    cmd_valid = 1'b0;
`ifdef SERVO_RAMP_EN
    check("abort_speed1_next", speed1, 160);
`else
    check("abort_speed1_next", speed1, 128);
`endif
    check("abort_ready_flushed", cmd_ready, 1);
    w = 0;
    while (busy !== 1'b0 && w < 300) begin
      @(negedge Clock);
      w++;
    end
    check("abort_returns_idle", busy, 0);
    check("abort_speed1_final", speed1, 128);
    check("abort_speed2_final", speed2, 128);
    repeat (5) @(negedge Clock);
    check("abort_stays_idle", busy, 0);
    check("abort_no_done", done_total - d0, 0);
  endtask

  task automatic reset_mid_test();
    int d0;
    d0 = done_total;
    @(negedge Clock);
`ifdef SERVO_RAMP_EN
    push_cmd(8'd220, 8'd128, 8'd0);
`else
    push_cmd(8'd160, 8'd128, 8'd5);
`endif
    wait_speed1(8'd160, "rst_reach_160");
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_speed1", speed1, 128);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    Reset = 1'b0;
    repeat (30) @(negedge Clock);
    check("rst_stays_idle", busy, 0);
    check("rst_no_done", done_total - d0, 0);
  endtask

  initial begin
    vecs[0] = '{s1: 8'd200, s2: 8'd128, frames: 8'd2, ch1: 18, ch2: 0};
    vecs[1] = '{s1: 8'd128, s2: 8'd128, frames: 8'd0, ch1: 18, ch2: 0};
    vecs[2] = '{s1: 8'd126, s2: 8'd128, frames: 8'd0, ch1: 1,  ch2: 0};
    vecs[3] = '{s1: 8'd2,   s2: 8'd128, frames: 8'd0, ch1: 31, ch2: 0};
    vecs[4] = '{s1: 8'd0,   s2: 8'd128, frames: 8'd1, ch1: 1,  ch2: 0};
    vecs[5] = '{s1: 8'd128, s2: 8'd255, frames: 8'd0, ch1: 32, ch2: 32};
    vecs[6] = '{s1: 8'd128, s2: 8'd128, frames: 8'd3, ch1: 0,  ch2: 32};

    Reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_speed1 = 8'd0;
    cmd_speed2 = 8'd0;
    cmd_frames = 8'd0;
    abort      = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("reset_speed1", speed1, 128);
    check("reset_speed2", speed2, 128);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", cmd_ready, 1);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      int p1, p2;
      p1 = (i == 0) ? 128 : int'(vecs[i-1].s1);
      p2 = (i == 0) ? 128 : int'(vecs[i-1].s2);
      run_vec(i, p1, p2);
    end

    fifo_test();
    abort_test();
    reset_mid_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
